// File: rtl/soc_trace_event_collector.sv
// Collects character-output events from per-core retirement traces into one ordered stream,
// tracking per-core termination, lost characters and a global idle watchdog.
module soc_trace_event_collector #(
   parameter int          NUM_CORES       = 8,
   parameter int          FIFO_DEPTH      = 16,
   parameter logic [31:0] TERM_INSN       = 32'h00100013,
   parameter logic [31:0] PUTC_INSN       = 32'h00400013,
   parameter int          WATCHDOG_CYCLES = 100000,
   localparam int         CID_W           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CORES-1:0]    trace_valid,
   input  logic [NUM_CORES*32-1:0] trace_insn,
   input  logic [NUM_CORES*32-1:0] trace_r3,
   output logic                    ev_valid,
   input  logic                    ev_ready,
   output logic [CID_W-1:0]        ev_core,
   output logic [7:0]              ev_char,
   output logic [NUM_CORES-1:0]    terminated,
   output logic [NUM_CORES-1:0]    overflow,
   output logic                    all_terminated,
   output logic                    watchdog_expired
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int WD_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WATCHDOG_CYCLES);

   logic [NUM_CORES-1:0] live_valid, is_putc, is_term, drain;
   logic [NUM_CORES-1:0] hold_full;
   logic [7:0]           hold_char [NUM_CORES];
   logic [CID_W-1:0]     last_grant, grant_idx, cand_idx;
   logic                 grant_any;
   int                   cand;

   logic [CID_W+7:0]     fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 fifo_full, push, pop;
   logic [WD_W-1:0]      wd_left;
   logic                 unused_r3_hi;

   assign live_valid = trace_valid & ~terminated;
   assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign push       = grant_any && !fifo_full;
   assign ev_valid   = (count != '0);
   assign pop        = ev_valid && ev_ready;
   assign ev_core    = fifo_mem[rd_ptr][CID_W+7:8];
   assign ev_char    = fifo_mem[rd_ptr][7:0];

   always_comb begin
      is_putc      = '0;
      is_term      = '0;
      drain        = '0;
      unused_r3_hi = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         is_putc[i]   = live_valid[i] && (trace_insn[32*i +: 32] == PUTC_INSN);
         is_term[i]   = live_valid[i] && (trace_insn[32*i +: 32] == TERM_INSN);
         drain[i]     = push && (grant_idx == CID_W'(i));
         unused_r3_hi = unused_r3_hi ^ (^trace_r3[32*i+8 +: 24]);
      end
   end

   // Round-robin search begins one past the last granted core.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int off = 1; off <= NUM_CORES; off++) begin
         cand     = (int'(last_grant) + off) % NUM_CORES;
         cand_idx = CID_W'(cand);
         if (!grant_any && hold_full[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {grant_idx, hold_char[grant_idx]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         terminated       <= '0;
         overflow         <= '0;
         hold_full        <= '0;
         last_grant       <= CID_W'(NUM_CORES - 1);
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         all_terminated   <= 1'b0;
         wd_left          <= WD_LOAD;
         watchdog_expired <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (is_term[i]) terminated[i] <= 1'b1;
            if (is_putc[i]) begin
               if (hold_full[i] && !drain[i]) begin
                  overflow[i] <= 1'b1;
               end else begin
                  hold_full[i] <= 1'b1;
                  hold_char[i] <= trace_r3[32*i +: 8];
               end
            end else if (drain[i]) begin
               hold_full[i] <= 1'b0;
            end
         end
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= grant_idx;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         all_terminated <= (&terminated) && !(|hold_full) && (count == '0);
         // Watchdog counts down idle cycles; expiry latches when it hits zero.
         if (|live_valid) begin
            wd_left <= WD_LOAD;
         end else if (!(&terminated) && (WATCHDOG_CYCLES != 0) && (wd_left != '0)) begin
            wd_left <= wd_left - 1'b1;
            if (wd_left == WD_W'(1)) watchdog_expired <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_soc_trace_event_collector.sv
// Directed bench for soc_trace_event_collector: stimulus pushes expected events into a queue,
// an independent monitor pops and compares each accepted output beat.
module tb_soc_trace_event_collector;
   localparam int          NC   = 8;
   localparam logic [31:0] TERM = 32'h00100013;
   localparam logic [31:0] PUTC = 32'h00400013;
   localparam logic [31:0] NOP  = 32'h00000013;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NC-1:0]   trace_valid = '0;
   logic [NC*32-1:0] trace_insn = '0;
   logic [NC*32-1:0] trace_r3 = '0;
   logic            ev_valid, ev_ready;
   logic [2:0]      ev_core;
   logic [7:0]      ev_char;
   logic [NC-1:0]   terminated, overflow;
   logic            all_terminated, watchdog_expired;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];

   soc_trace_event_collector #(
      .NUM_CORES(NC), .FIFO_DEPTH(16), .TERM_INSN(TERM), .PUTC_INSN(PUTC), .WATCHDOG_CYCLES(10)
   ) dut (
      .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_insn(trace_insn),
      .trace_r3(trace_r3), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_core(ev_core),
      .ev_char(ev_char), .terminated(terminated), .overflow(overflow),
      .all_terminated(all_terminated), .watchdog_expired(watchdog_expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {ev_core, ev_char}, 11'h7ff);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            check("ev_core", 64'(ev_core), 64'(e[10:8]));
            check("ev_char", 64'(ev_char), 64'(e[7:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      trace_valid = '0;
      trace_insn  = '0;
      trace_r3    = '0;
   endtask

   task automatic drive(input int core, input logic [31:0] insn, input logic [7:0] ch);
      trace_valid[core]         = 1'b1;
      trace_insn[32*core +: 32] = insn;
      trace_r3[32*core +: 32]   = {24'h0, ch};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ev_valid) && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout", 64'(n >= 200), 64'(0));
   endtask

   initial begin
      ev_ready = 1'b1;
      do_reset();
      check("rst_ev_valid", 64'(ev_valid), 0);
      check("rst_terminated", 64'(terminated), 0);
      check("rst_overflow", 64'(overflow), 0);
      check("rst_all_term", 64'(all_terminated), 0);
      check("rst_wdog", 64'(watchdog_expired), 0);

      // Watchdog: expires after 10 idle edges
      repeat (9) tick();
      check("wdog_9", 64'(watchdog_expired), 0);
      tick();
      check("wdog_10", 64'(watchdog_expired), 1);

      // Watchdog restart by a valid at cycle 9
      do_reset();
      repeat (8) tick();
      drive(0, NOP, 8'h00);
      tick();
      clear_in();
      tick();
      check("wdog_restart_10", 64'(watchdog_expired), 0);
      repeat (8) tick();
      check("wdog_restart_18", 64'(watchdog_expired), 0);
      tick();
      check("wdog_restart_19", 64'(watchdog_expired), 1);

      // Single event latency
      do_reset();
      repeat (4) tick();
      drive(2, PUTC, 8'h41);
      exp_q.push_back({3'd2, 8'h41});
      tick();
      clear_in();
      check("lat_n1_valid", 64'(ev_valid), 0);
      tick();
      check("lat_n2_valid", 64'(ev_valid), 1);
      check("lat_n2_core", 64'(ev_core), 2);
      check("lat_n2_char", 64'(ev_char), 64'h41);
      tick();
      check("lat_single_beat", 64'(ev_valid), 0);

      // Round-robin ordering
      do_reset();
      drive(0, PUTC, 8'h10); drive(3, PUTC, 8'h13); drive(5, PUTC, 8'h15);
      exp_q.push_back({3'd0, 8'h10}); exp_q.push_back({3'd3, 8'h13}); exp_q.push_back({3'd5, 8'h15});
      tick();
      clear_in();
      tick();
      check("rr_first_core", 64'(ev_core), 0);
      tick();
      check("rr_second_core", 64'(ev_core), 3);
      tick();
      check("rr_third_core", 64'(ev_core), 5);
      wait_drain();
      drive(3, PUTC, 8'h23); drive(0, PUTC, 8'h20);
      exp_q.push_back({3'd0, 8'h20}); exp_q.push_back({3'd3, 8'h23});
      tick();
      clear_in();
      wait_drain();

      // FIFO fill and overflow on core 1
      do_reset();
      ev_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         drive(1, PUTC, 8'h60 + 8'(i));
         if (i < 17) exp_q.push_back({3'd1, 8'h60 + 8'(i)});
         tick();
      end
      clear_in();
      check("ovf_flag", 64'(overflow), 64'h02);
      check("ovf_term", 64'(terminated), 0);
      check("ovf_ev_valid", 64'(ev_valid), 1);
      ev_ready = 1'b1;
      wait_drain();
      check("ovf_sticky", 64'(overflow), 64'h02);

      // Termination with queued events
      do_reset();
      ev_ready = 1'b0;
      drive(4, PUTC, 8'h34); drive(6, PUTC, 8'h36);
      exp_q.push_back({3'd4, 8'h34}); exp_q.push_back({3'd6, 8'h36});
      tick();
      clear_in();
      for (int c = 0; c < NC; c++) drive(c, TERM, 8'h00);
      tick();
      clear_in();
      repeat (3) tick();
      check("term_all", 64'(terminated), 64'hff);
      check("term_at_queued", 64'(all_terminated), 0);
      drive(0, PUTC, 8'h30);
      tick();
      clear_in();
      check("term_at_queued2", 64'(all_terminated), 0);
      ev_ready = 1'b1;
      tick();
      check("term_at_pop1", 64'(all_terminated), 0);
      tick();
      check("term_at_empty", 64'(all_terminated), 0);
      tick();
      check("term_at_set", 64'(all_terminated), 1);
      repeat (3) tick();
      check("term_ignored_putc", 64'(ev_valid), 0);

      // Mid-operation reset
      do_reset();
      ev_ready = 1'b0;
      for (int c = 0; c < 5; c++) drive(c, PUTC, 8'h50 + 8'(c));
      tick();
      clear_in();
      for (int c = 0; c < 4; c++) drive(c, TERM, 8'h00);
      tick();
      clear_in();
      repeat (6) tick();
      check("mid_term", 64'(terminated), 64'h0f);
      check("mid_ev_valid", 64'(ev_valid), 1);
      rst = 1'b1;
      drive(5, PUTC, 8'h55);
      tick();
      rst = 1'b0;
      clear_in();
      exp_q.delete();
      check("mid_rst_valid", 64'(ev_valid), 0);
      check("mid_rst_term", 64'(terminated), 0);
      check("mid_rst_ovf", 64'(overflow), 0);
      tick();
      check("mid_rst_valid2", 64'(ev_valid), 0);

      check("queue_leftover", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
